proj001_arb: RTL and testbench

PROJ001_ARB -- requirements
Module: proj001_arb

---
 rtl/proj001_arb.sv | 180 ++++++++++++++++++
 tb/tb_proj001_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj001_arb.sv
// Two-requester round-robin front end for a shared serial-capture ALU.
// Optional WAIT-state abort after TIMEOUT idle cycles: define ARB_TIMEOUT_EN.
module proj001_arb #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [4:0] res,
  output logic       err,
  output logic [3:0] alu_d_in,
  output logic [1:0] alu_op,
  output logic       alu_capture,
  input  logic       alu_valid,
  input  logic [4:0] alu_result
);

  typedef enum logic [2:0] {IDLE, CAP_A, CAP_B, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic       ptr;
  logic       win;
  logic       sel;
  logic [3:0] a_q, b_q;
  logic [1:0] op_q;
  logic [4:0] result_q;

  logic       gnt0_n, gnt1_n, done0_n, done1_n, cap_n, err_n;
  logic [3:0] din_n;
  logic [1:0] op_n;
  logic [4:0] res_n;

  if (TIMEOUT == 0) begin : g_timeout_range
    $error("TIMEOUT must be at least 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          to_q;
  logic          expire;
  assign expire = (cnt == CW'(TIMEOUT - 1)) && !alu_valid;
`else
  assign err = 1'b0;
`endif

  // ptr names the requester that wins a tie
  assign sel = (req0 && req1) ? ptr : req1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = CAP_A;
      CAP_A:   state_nxt = CAP_B;
      CAP_B:   state_nxt = WAIT;
      WAIT: begin
        if (alu_valid) state_nxt = DONE;
`ifdef ARB_TIMEOUT_EN
        else if (expire) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so each
  // state's outputs appear one cycle after the state is entered.
  always_comb begin
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
    cap_n   = 1'b0;
    din_n   = '0;
    op_n    = '0;
    res_n   = res;
    err_n   = 1'b0;
    case (state)
      CAP_A: begin
        gnt0_n = !win;
        gnt1_n = win;
        cap_n  = 1'b1;
        din_n  = a_q;
        op_n   = op_q;
      end
      CAP_B: begin
        cap_n = 1'b1;
        din_n = b_q;
        op_n  = op_q;
      end
      DONE: begin
        done0_n = !win;
        done1_n = win;
        res_n   = result_q;
`ifdef ARB_TIMEOUT_EN
        err_n   = to_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      win         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      alu_capture <= 1'b0;
      alu_d_in    <= '0;
      alu_op      <= '0;
      res         <= '0;
`ifdef ARB_TIMEOUT_EN
      err         <= 1'b0;
      cnt         <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      gnt0        <= gnt0_n;
      gnt1        <= gnt1_n;
      done0       <= done0_n;
      done1       <= done1_n;
      alu_capture <= cap_n;
      alu_d_in    <= din_n;
      alu_op      <= op_n;
      res         <= res_n;
`ifdef ARB_TIMEOUT_EN
      err         <= err_n;
      cnt         <= (state == WAIT && !alu_valid && !expire) ? cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win  <= sel;
            a_q  <= sel ? a1 : a0;
            b_q  <= sel ? b1 : b0;
            op_q <= sel ? op1 : op0;
          end
        end
        WAIT: begin
          if (alu_valid) begin
            result_q <= alu_result;
`ifdef ARB_TIMEOUT_EN
            to_q     <= 1'b0;
          end else if (expire) begin
            result_q <= '0;
            to_q     <= 1'b1;
`endif
          end
        end
        DONE:    ptr <= !win;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proj001_arb.sv
// Directed bench for proj001_arb: grant/done expectations are queued when a
// request or ALU result is driven and consumed by a negedge monitor.
module tb_proj001_arb;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, a1, b0, b1;
  logic [1:0] op0, op1;
  logic       gnt0, gnt1, done0, done1, err;
  logic [4:0] res;
  logic [3:0] alu_d_in;
  logic [1:0] alu_op;
  logic       alu_capture;
  logic       alu_valid;
  logic [4:0] alu_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } gnt_t;

  typedef struct {
    int         id;
    logic [4:0] res;
    logic       err;
  } done_t;

  gnt_t  gq[$];
  done_t dq[$];

  proj001_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .res(res), .err(err),
    .alu_d_in(alu_d_in), .alu_op(alu_op), .alu_capture(alu_capture),
    .alu_valid(alu_valid), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: grant order/capture sequence, idle ALU outputs, done contents.
  initial begin
    gnt_t       ge;
    done_t      de;
    bit         b_pend;
    logic [3:0] b_exp;
    logic [1:0] op_exp;
    b_pend = 1'b0;
    b_exp  = '0;
    op_exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        b_pend = 1'b0;
      end else begin
        chk("gnt_excl", 32'(gnt0 & gnt1), 32'(0));
        chk("done_excl", 32'(done0 & done1), 32'(0));
        if (b_pend) begin
          chk("cap_b", 32'({alu_capture, alu_op, alu_d_in}), 32'({1'b1, op_exp, b_exp}));
          b_pend = 1'b0;
        end else if (gnt0 | gnt1) begin
          chk("gnt_queued", 32'(gq.size() != 0), 32'(1));
          if (gq.size() != 0) begin
            ge = gq.pop_front();
            chk("gnt_id", 32'(gnt1), 32'(ge.id));
            chk("cap_a", 32'({alu_capture, alu_op, alu_d_in}), 32'({1'b1, ge.op, ge.a}));
            b_pend = 1'b1;
            b_exp  = ge.b;
            op_exp = ge.op;
          end
        end else begin
          chk("alu_idle", 32'({alu_capture, alu_op, alu_d_in}), 32'(0));
        end
        if (done0 | done1) begin
          chk("done_queued", 32'(dq.size() != 0), 32'(1));
          if (dq.size() != 0) begin
            de = dq.pop_front();
            chk("done_id", 32'(done1), 32'(de.id));
            chk("done_res", 32'(res), 32'(de.res));
            chk("done_err", 32'(err), 32'(de.err));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_gnt(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    gq.push_back('{id: id, a: a, b: b, op: op});
  endtask

  task automatic drive_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (id == 0) begin
      req0 = 1'b1; a0 = a; b0 = b; op0 = op;
    end else begin
      req1 = 1'b1; a1 = a; b1 = b; op1 = op;
    end
    exp_gnt(id, a, b, op);
  endtask

  task automatic wait_gnt(input int id);
    int seen;
    seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      @(negedge clk);
      if (gnt0) seen = 0;
      else if (gnt1) seen = 1;
    end
    chk("gnt_wait", 32'(seen), 32'(id));
  endtask

  // Returns at the negedge where done is high, before the next IDLE edge.
  task automatic run_txn(input int id, input int d, input logic [4:0] result,
                         input bit spur, input bit keep);
    wait_gnt(id);
    if (!keep) begin
      if (id == 0) req0 = 1'b0;
      else         req1 = 1'b0;
    end
    if (spur) begin
      alu_valid  = 1'b1;
      alu_result = 5'h1F;
    end
    repeat (d) begin
      @(negedge clk);
      alu_valid = 1'b0;
    end
    alu_valid  = 1'b1;
    alu_result = result;
    dq.push_back('{id: id, res: result, err: 1'b0});
    @(negedge clk);
    alu_valid = 1'b0;
    @(negedge clk);
    chk("done_latency", 32'(id != 0 ? done1 : done0), 32'(1));
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0;
    alu_valid = 1'b0; alu_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
    chk("rst_done", 32'({done0, done1}), 32'(0));
    chk("rst_res", 32'(res), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_alu", 32'({alu_capture, alu_op, alu_d_in}), 32'(0));
    rst = 1'b0;

    // Simultaneous requests after reset: 0 then 1, twice.
    drive_req(0, 4'h1, 4'h2, 2'd1);
    drive_req(1, 4'h6, 4'h9, 2'd2);
    run_txn(0, 1, 5'h03, 1'b0, 1'b0);
    run_txn(1, 2, 5'h0F, 1'b0, 1'b0);
    drive_req(0, 4'hA, 4'h3, 2'd0);
    drive_req(1, 4'h2, 4'hE, 2'd3);
    run_txn(0, 1, 5'h0D, 1'b0, 1'b0);
    run_txn(1, 1, 5'h10, 1'b0, 1'b0);

    // Single request, result on the second WAIT cycle.
    drive_req(0, 4'd3, 4'd5, 2'd0);
    run_txn(0, 2, 5'd8, 1'b0, 1'b0);

    // Requester 1 finishes alone, then a tie goes to 0.
    drive_req(1, 4'hF, 4'h1, 2'd1);
    run_txn(1, 3, 5'h1E, 1'b0, 1'b0);
    drive_req(0, 4'h4, 4'hC, 2'd2);
    drive_req(1, 4'h8, 4'h0, 2'd0);
    run_txn(0, 1, 5'h0A, 1'b0, 1'b0);
    run_txn(1, 1, 5'h02, 1'b0, 1'b0);

    // Both held: grants alternate 0,1,0,1.
    drive_req(0, 4'h5, 4'h5, 2'd2);
    drive_req(1, 4'h7, 4'h8, 2'd3);
    exp_gnt(0, 4'h5, 4'h5, 2'd2);
    exp_gnt(1, 4'h7, 4'h8, 2'd3);
    run_txn(0, 1, 5'h01, 1'b0, 1'b1);
    run_txn(1, 1, 5'h14, 1'b0, 1'b1);
    run_txn(0, 2, 5'h05, 1'b0, 1'b1);
    run_txn(1, 1, 5'h11, 1'b0, 1'b0);
    req0 = 1'b0;

    // Spurious valid in IDLE leaves res alone.
    alu_valid  = 1'b1;
    alu_result = 5'h1F;
    @(negedge clk);
    alu_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_idle_res", 32'(res), 32'(5'h11));

    // Spurious valid while in CAP_B is ignored.
    drive_req(0, 4'h2, 4'h6, 2'd1);
    run_txn(0, 2, 5'h07, 1'b1, 1'b0);

    // Reset during WAIT aborts; priority returns to requester 0.
    drive_req(0, 4'h7, 4'h2, 2'd3);
    wait_gnt(0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_res", 32'(res), 32'(0));
    chk("abort_done", 32'({done0, done1}), 32'(0));
    chk("abort_gnt", 32'({gnt0, gnt1}), 32'(0));
    chk("abort_alu", 32'({alu_capture, alu_op, alu_d_in}), 32'(0));
    chk("abort_err", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    alu_valid  = 1'b1;
    alu_result = 5'h19;
    @(negedge clk);
    alu_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_hold_res", 32'(res), 32'(0));
    drive_req(0, 4'h3, 4'h3, 2'd1);
    drive_req(1, 4'hB, 4'h4, 2'd2);
    run_txn(0, 1, 5'h06, 1'b0, 1'b0);
    run_txn(1, 2, 5'h0F, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    drive_req(0, 4'h9, 4'h9, 2'd1);
    dq.push_back('{id: 0, res: 5'd0, err: 1'b1});
    wait_gnt(0);
    req0 = 1'b0;
    repeat (TO + 1) @(negedge clk);
    chk("timeout_early", 32'(done0), 32'(0));
    @(negedge clk);
    chk("timeout_done", 32'(done0), 32'(1));
`else
    drive_req(0, 4'h9, 4'h9, 2'd1);
    wait_gnt(0);
    req0 = 1'b0;
    repeat (3 * TO) begin
      @(negedge clk);
      chk("no_timeout", 32'(done0), 32'(0));
    end
    alu_valid  = 1'b1;
    alu_result = 5'h15;
    dq.push_back('{id: 0, res: 5'h15, err: 1'b0});
    @(negedge clk);
    alu_valid = 1'b0;
    @(negedge clk);
    chk("late_done", 32'(done0), 32'(1));
`endif

    repeat (3) @(negedge clk);
    chk("gq_drained", 32'(gq.size()), 32'(0));
    chk("dq_drained", 32'(dq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
